// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the hard-wired zero register specifier.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FREEZE   = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    FREEZE   = ST_FREEZE,
    REDIRECT = ST_REDIRECT
  } state_t;

endpackage

// File: rtl/hazard_watchdog.sv
// Busy watchdog: counts consecutive data-memory busy cycles (saturating at
// TIMEOUT_CYC) and raises a sticky error once the limit is reached.
module hazard_watchdog #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_CNT_W    = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic count_en,
  output logic timeout_err
);

  localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(TIMEOUT_CYC);

  logic [TO_CNT_W-1:0] count;
  logic [TO_CNT_W-1:0] count_next;

  // Next count: cleared as soon as memory is ready, otherwise step toward the limit and hold there.
  always_comb begin
    count_next = count;
    if (!count_en) begin
      count_next = '0;
    end else if (count != LIMIT) begin
      count_next = count + 1'b1;
    end
  end

  // Counter register plus sticky error; only reset can clear the error.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count       <= '0;
      timeout_err <= 1'b0;
    end else begin
      count <= count_next;
      if (count_en && (count_next == LIMIT)) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// squash and whole-pipeline freeze while data memory is busy.
// Optional feature macro: HAZARD_PERF_CNT_EN adds Stall_Cnt / Flush_Cnt.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_CNT_W    = 8
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRt,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_Rt,
  input  logic                  PCSrc,
  input  logic                  Mem_Busy,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  IDEX_Bubble,
  output logic                  IFID_Flush,
  output logic                  EXMEM_Flush,
  output logic                  Pipe_Freeze,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           Stall_Cnt,
  output logic [31:0]           Flush_Cnt,
`endif
  output logic                  Timeout_Err
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(REG_ZERO);

  state_t state_q;
  state_t state_d;
  logic   in_redirect;
  logic   eff_valid;
  logic   lu_hit;
  logic   lu_stall;
  logic   flush_take;

  // Load-use detection; the refetched slot right after a redirect is never treated as valid.
  always_comb begin
    in_redirect = (state_q == REDIRECT);
    eff_valid   = ID_Valid && !in_redirect;
    lu_hit      = EX_MemRead && eff_valid && (EX_Rt != ZERO_REG) &&
                  ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
  end

  // Next-state and same-cycle output decode; priority is busy, then branch, then load-use.
  always_comb begin
    state_d     = RUN;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    Pipe_Freeze = 1'b0;
    lu_stall    = 1'b0;
    flush_take  = 1'b0;
    if (!Reset_n) begin
      state_d = RUN;
    end else if (Mem_Busy) begin
      Pipe_Freeze = 1'b1;
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      state_d     = FREEZE;
    end else if (PCSrc && !in_redirect) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      EXMEM_Flush = 1'b1;
      flush_take  = 1'b1;
      state_d     = REDIRECT;
    end else if (lu_hit) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEX_Bubble = 1'b1;
      lu_stall    = 1'b1;
      state_d     = RUN;
    end
  end

  // State register; an asynchronous reset drops straight back to RUN.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  hazard_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_CNT_W    (TO_CNT_W)
  ) u_watchdog (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .count_en    (Mem_Busy),
    .timeout_err (Timeout_Err)
  );

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters: stall cycles (load-use or freeze) and taken-branch flushes, wrapping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else begin
      if (lu_stall || Pipe_Freeze) begin
        Stall_Cnt <= Stall_Cnt + 32'd1;
      end
      if (flush_take) begin
        Flush_Cnt <= Flush_Cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic against a behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

  localparam int REG_ADDR_W  = 5;
  localparam int TIMEOUT_CYC = 255;
  localparam int TO_CNT_W    = 8;

  logic                  Clk = 1'b0;
  logic                  Reset_n;
  logic                  ID_Valid;
  logic [REG_ADDR_W-1:0] ID_Rs;
  logic [REG_ADDR_W-1:0] ID_Rt;
  logic                  ID_UsesRt;
  logic                  EX_MemRead;
  logic [REG_ADDR_W-1:0] EX_Rt;
  logic                  PCSrc;
  logic                  Mem_Busy;
  logic                  PCWrite;
  logic                  IFIDWrite;
  logic                  IDEX_Bubble;
  logic                  IFID_Flush;
  logic                  EXMEM_Flush;
  logic                  Pipe_Freeze;
  logic                  Timeout_Err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]           Stall_Cnt;
  logic [31:0]           Flush_Cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Model state: did the previous cycle take a branch flush, how many
  // consecutive busy cycles have elapsed, and has the watchdog fired.
  bit m_after_flush;
  int m_busy_run;
  bit m_err;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (REG_ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_CNT_W    (TO_CNT_W)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ID_Valid    (ID_Valid),
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_UsesRt   (ID_UsesRt),
    .EX_MemRead  (EX_MemRead),
    .EX_Rt       (EX_Rt),
    .PCSrc       (PCSrc),
    .Mem_Busy    (Mem_Busy),
    .PCWrite     (PCWrite),
    .IFIDWrite   (IFIDWrite),
    .IDEX_Bubble (IDEX_Bubble),
    .IFID_Flush  (IFID_Flush),
    .EXMEM_Flush (EXMEM_Flush),
    .Pipe_Freeze (Pipe_Freeze),
`ifdef HAZARD_PERF_CNT_EN
    .Stall_Cnt   (Stall_Cnt),
    .Flush_Cnt   (Flush_Cnt),
`endif
    .Timeout_Err (Timeout_Err)
  );

  always #5 Clk = ~Clk;

  // Output vector order: PCWrite IFIDWrite IDEX_Bubble IFID_Flush EXMEM_Flush Pipe_Freeze Timeout_Err
  function automatic logic [6:0] dut_out();
    return {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, EXMEM_Flush, Pipe_Freeze, Timeout_Err};
  endfunction

  function automatic logic [6:0] model_out();
    logic hit;
    logic [6:0] r;
    hit = EX_MemRead && ID_Valid && !m_after_flush && (EX_Rt != 0) &&
          ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
    if (Mem_Busy)                      r = 7'b0000010;
    else if (PCSrc && !m_after_flush)  r = 7'b1111100;
    else if (hit)                      r = 7'b0010000;
    else                               r = 7'b1100000;
    r[0] = m_err;
    return r;
  endfunction

  task automatic model_step();
    if (Mem_Busy) begin
      m_busy_run = (m_busy_run < TIMEOUT_CYC) ? m_busy_run + 1 : TIMEOUT_CYC;
      if (m_busy_run >= TIMEOUT_CYC) m_err = 1'b1;
      m_after_flush = 1'b0;
    end else begin
      m_busy_run    = 0;
      m_after_flush = PCSrc && !m_after_flush;
    end
  endtask

  task automatic model_reset();
    m_after_flush = 1'b0;
    m_busy_run    = 0;
    m_err         = 1'b0;
  endtask

  task automatic check7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with inputs applied; checks, clocks once, advances the model.
  task automatic applyStimulus(input string tag, input bit use_const, input logic [6:0] const_exp);
    logic [6:0] exp;
    exp = model_out();
    #1;
    check7(tag, dut_out(), exp);
    if (use_const) check7({tag, "_const"}, dut_out(), const_exp);
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic clearInputs();
    ID_Valid   = 1'b0;
    ID_Rs      = '0;
    ID_Rt      = '0;
    ID_UsesRt  = 1'b0;
    EX_MemRead = 1'b0;
    EX_Rt      = '0;
    PCSrc      = 1'b0;
    Mem_Busy   = 1'b0;
  endtask

  task automatic pulseReset(input string tag);
    @(negedge Clk);
    Reset_n = 1'b0;
    model_reset();
    #2;
    check7(tag, dut_out(), 7'b1100000);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0;
    clearInputs();
    model_reset();
    #12;
    check7("reset_values", dut_out(), 7'b1100000);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Load-use on Rs, then the bubble occupies EX.
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_Valid = 1'b1;
    applyStimulus("lu_stall", 1'b1, 7'b0010000);
    EX_MemRead = 1'b0;
    applyStimulus("lu_release", 1'b1, 7'b1100000);

    // $zero destination never stalls; Rt match only counts when Rt is read.
    EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
    applyStimulus("zero_reg", 1'b1, 7'b1100000);
    EX_Rt = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd3; ID_UsesRt = 1'b0;
    applyStimulus("rt_unused", 1'b1, 7'b1100000);
    ID_UsesRt = 1'b1;
    applyStimulus("rt_used", 1'b1, 7'b0010000);

    // Taken branch flushes; the refetched slot cannot trigger a stall.
    clearInputs();
    PCSrc = 1'b1;
    applyStimulus("branch_flush", 1'b1, 7'b1111100);
    PCSrc = 1'b0; EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_Valid = 1'b1;
    applyStimulus("redirect_mask", 1'b1, 7'b1100000);
    applyStimulus("mask_one_cycle", 1'b1, 7'b0010000);

    // Priority: flush beats load-use; busy beats flush; held branch acts when busy clears.
    PCSrc = 1'b1;
    applyStimulus("flush_over_lu", 1'b1, 7'b1111100);
    clearInputs();
    applyStimulus("after_flush", 1'b1, 7'b1100000);
    Mem_Busy = 1'b1; PCSrc = 1'b1;
    applyStimulus("busy_over_flush", 1'b1, 7'b0000010);
    applyStimulus("freeze_hold", 1'b1, 7'b0000010);
    Mem_Busy = 1'b0;
    applyStimulus("freeze_exit_flush", 1'b1, 7'b1111100);
    PCSrc = 1'b0;
    applyStimulus("post_exit", 1'b1, 7'b1100000);

    // Watchdog: error appears after the 255th consecutive busy cycle and sticks.
    Mem_Busy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 254 || i == 255) begin
        #1;
        check1($sformatf("watchdog_edge_%0d", i), Timeout_Err, (i >= TIMEOUT_CYC) ? 1'b1 : 1'b0);
        #1;
        applyStimulus("watchdog_run", 1'b0, 7'b0);
      end else begin
        applyStimulus("watchdog_run", 1'b0, 7'b0);
      end
    end
    Mem_Busy = 1'b0;
    applyStimulus("err_sticky", 1'b1, 7'b1100001);
    applyStimulus("err_sticky2", 1'b1, 7'b1100001);
    pulseReset("err_reset");
    check1("err_cleared", Timeout_Err, 1'b0);

    // Asynchronous reset in the middle of a freeze, with Mem_Busy still high.
    Mem_Busy = 1'b1;
    applyStimulus("pre_async_freeze", 1'b0, 7'b0);
    applyStimulus("pre_async_freeze", 1'b0, 7'b0);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check7("async_reset", dut_out(), 7'b1100000);
    Mem_Busy = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    EX_MemRead = 1'b1; EX_Rt = 5'd4; ID_Rt = 5'd4; ID_UsesRt = 1'b1; ID_Valid = 1'b1;
    applyStimulus("post_async_run", 1'b1, 7'b0010000);

    // Randomized traffic with a small register pool so hazards occur often.
    for (int n = 0; n < 3000; n++) begin
      ID_Valid   = ($urandom_range(0, 3) != 0);
      ID_Rs      = REG_ADDR_W'($urandom_range(0, 3));
      ID_Rt      = REG_ADDR_W'($urandom_range(0, 3));
      ID_UsesRt  = $urandom_range(0, 1) == 1;
      EX_MemRead = $urandom_range(0, 1) == 1;
      EX_Rt      = REG_ADDR_W'($urandom_range(0, 3));
      PCSrc      = ($urandom_range(0, 3) == 0);
      Mem_Busy   = ($urandom_range(0, 4) == 0);
      applyStimulus("random", 1'b0, 7'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
